// File: rtl/quicksort_pkg.sv
// Shared types, sizes and the constant source table for the quicksort block.
package quicksort_pkg;

    localparam int unsigned N     = 16;
    localparam int unsigned IDX_W = 4;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [7:0]       byte_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COPY,
        S_POP,
        S_PART,
        S_PLACE,
        S_DONE
    } state_t;

    // Signed bytes: 12,-3,45,7,0,-128,99,7,33,-1,64,5,-50,127,2,18
    localparam byte_t SRC_TABLE [N] = '{
        8'h0C, 8'hFD, 8'h2D, 8'h07, 8'h00, 8'h80, 8'h63, 8'h07,
        8'h21, 8'hFF, 8'h40, 8'h05, 8'hCE, 8'h7F, 8'h02, 8'h12
    };

    // True when a 7-bit byte address falls inside [base, base+N).
    function automatic logic in_range(input logic [6:0] addr, input int unsigned base);
        int unsigned a;
        a = 32'(addr);
        return (a >= base) && (a < base + N);
    endfunction

    // Entry index of an address relative to a window base.
    function automatic idx_t offset_of(input logic [6:0] addr, input int unsigned base);
        return idx_t'(addr - 7'(base));
    endfunction

    // Write mask (1<<size)-1, saturating at a full byte.
    function automatic byte_t size_mask(input logic [3:0] size);
        logic [15:0] m;
        m = (16'd1 << size) - 16'd1;
        return m[7:0];
    endfunction

endpackage

// File: rtl/qs_range_stack.sv
// LIFO of (lo,hi) index pairs; can take two pushes in one cycle (a below b).
module qs_range_stack
    import quicksort_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic push_a_i,
    input  logic push_b_i,
    input  logic pop_i,
    input  idx_t a_lo_i,
    input  idx_t a_hi_i,
    input  idx_t b_lo_i,
    input  idx_t b_hi_i,
    output logic empty_o,
    output idx_t top_lo_o,
    output idx_t top_hi_o
);

    idx_t        lo_mem [N];
    idx_t        hi_mem [N];
    logic [4:0]  cnt_q, cnt_d;
    idx_t        slot_a, slot_b, top_idx;

    assign empty_o  = (cnt_q == 5'd0);
    assign slot_a   = cnt_q[3:0];
    assign slot_b   = cnt_q[3:0] + {3'b000, push_a_i};
    assign top_idx  = idx_t'(cnt_q - 5'd1);
    assign top_lo_o = lo_mem[top_idx];
    assign top_hi_o = hi_mem[top_idx];

    // Occupancy count: pop removes one, pushes add up to two.
    always_comb begin
        cnt_d = cnt_q;
        if (pop_i && !empty_o) begin
            cnt_d = cnt_q - 5'd1;
        end else begin
            cnt_d = cnt_q + {4'b0000, push_a_i} + {4'b0000, push_b_i};
        end
    end

    // Count register; reset empties the stack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; contents are only meaningful below the count.
    always_ff @(posedge clk) begin
        if (push_a_i) begin
            lo_mem[slot_a] <= a_lo_i;
            hi_mem[slot_a] <= a_hi_i;
        end
        if (push_b_i) begin
            lo_mem[slot_b] <= b_lo_i;
            hi_mem[slot_b] <= b_hi_i;
        end
    end

endmodule

// File: rtl/quicksort_main.sv
// In-place Lomuto quicksort of a 16-byte RAM seeded from a constant table,
// with two slave channels for reading/writing the RAM and reading the table.
module quicksort_main
    import quicksort_pkg::*;
#(
    parameter int unsigned MEM_var_28860_28869 = 32,
    parameter int unsigned MEM_var_29131_28866 = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_port,
    input  logic [1:0]  S_oe_ram,
    input  logic [1:0]  S_we_ram,
    input  logic [13:0] S_addr_ram,
    input  logic [15:0] S_Wdata_ram,
    input  logic [7:0]  S_data_ram_size,
    input  logic [15:0] M_Rdata_ram,
    input  logic [1:0]  M_DataRdy,
    output logic        done_port,
    output logic [15:0] Sout_Rdata_ram,
    output logic [1:0]  Sout_DataRdy,
    output logic [1:0]  Mout_oe_ram,
    output logic [1:0]  Mout_we_ram,
    output logic [13:0] Mout_addr_ram,
    output logic [15:0] Mout_Wdata_ram,
    output logic [7:0]  Mout_data_ram_size
);

    state_t      state_q, state_d;
    idx_t        lo_q, lo_d, hi_q, hi_d, i_q, i_d, j_q, j_d;
    byte_t       pivot_q, pivot_d;
    byte_t       ram_q [N];
    byte_t       ram_d [N];
    logic [15:0] rdata_q, rdata_d;
    logic [1:0]  rdy_q, rdy_d;

    logic        push_a, push_b, pop, stk_empty;
    idx_t        a_lo, a_hi, b_lo, b_hi, top_lo, top_hi;

    logic [6:0]  ch_addr  [2];
    byte_t       ch_wdata [2];
    byte_t       ch_mask  [2];
    logic        ch_rd    [2];
    logic        ch_wr    [2];
    logic        host_ok;
    logic        unused_master;

    assign unused_master      = ^{M_Rdata_ram, M_DataRdy};
    assign Mout_oe_ram        = '0;
    assign Mout_we_ram        = '0;
    assign Mout_addr_ram      = '0;
    assign Mout_Wdata_ram     = '0;
    assign Mout_data_ram_size = '0;
    assign Sout_Rdata_ram     = rdata_q;
    assign Sout_DataRdy       = rdy_q;
    assign host_ok            = (state_q == S_IDLE) || (state_q == S_DONE);

    qs_range_stack u_stack (
        .clk      (clock),
        .rst      (reset),
        .push_a_i (push_a),
        .push_b_i (push_b),
        .pop_i    (pop),
        .a_lo_i   (a_lo),
        .a_hi_i   (a_hi),
        .b_lo_i   (b_lo),
        .b_hi_i   (b_hi),
        .empty_o  (stk_empty),
        .top_lo_o (top_lo),
        .top_hi_o (top_hi)
    );

    // Slave decode: a read wins over a write on the same channel; RAM window shadows the table.
    always_comb begin
        rdata_d = '0;
        rdy_d   = '0;
        for (int unsigned c = 0; c < 2; c++) begin
            ch_addr[c]  = S_addr_ram[7*c +: 7];
            ch_wdata[c] = S_Wdata_ram[8*c +: 8];
            ch_mask[c]  = size_mask(S_data_ram_size[4*c +: 4]);
            ch_rd[c]    = S_oe_ram[c] && (in_range(ch_addr[c], MEM_var_29131_28866) ||
                                          in_range(ch_addr[c], MEM_var_28860_28869));
            ch_wr[c]    = S_we_ram[c] && !S_oe_ram[c] && host_ok &&
                          in_range(ch_addr[c], MEM_var_29131_28866);
            rdy_d[c]    = ch_rd[c] || ch_wr[c];
            if (ch_rd[c]) begin
                if (in_range(ch_addr[c], MEM_var_29131_28866)) begin
                    rdata_d[8*c +: 8] = ram_q[offset_of(ch_addr[c], MEM_var_29131_28866)];
                end else begin
                    rdata_d[8*c +: 8] = SRC_TABLE[offset_of(ch_addr[c], MEM_var_28860_28869)];
                end
            end
        end
    end

    // Sort FSM next state, RAM updates and stack control; host writes applied last (channel 1 last).
    always_comb begin
        state_d   = state_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        i_d       = i_q;
        j_d       = j_q;
        pivot_d   = pivot_q;
        ram_d     = ram_q;
        push_a    = 1'b0;
        push_b    = 1'b0;
        pop       = 1'b0;
        a_lo      = '0;
        a_hi      = '0;
        b_lo      = '0;
        b_hi      = '0;
        done_port = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_port) begin
                    j_d     = '0;
                    state_d = S_COPY;
                end
            end
            S_COPY: begin
                ram_d[j_q] = SRC_TABLE[j_q];
                if (j_q == idx_t'(N - 1)) begin
                    push_a  = 1'b1;
                    a_lo    = '0;
                    a_hi    = idx_t'(N - 1);
                    state_d = S_POP;
                end else begin
                    j_d = j_q + 4'd1;
                end
            end
            S_POP: begin
                if (stk_empty) begin
                    state_d = S_DONE;
                end else begin
                    pop = 1'b1;
                    if (top_lo < top_hi) begin
                        lo_d    = top_lo;
                        hi_d    = top_hi;
                        i_d     = top_lo;
                        j_d     = top_lo;
                        pivot_d = ram_q[top_hi];
                        state_d = S_PART;
                    end
                end
            end
            S_PART: begin
                if ($signed(ram_q[j_q]) < $signed(pivot_q)) begin
                    ram_d[i_q] = ram_q[j_q];
                    ram_d[j_q] = ram_q[i_q];
                    i_d        = i_q + 4'd1;
                end
                if (j_q == hi_q - 4'd1) begin
                    state_d = S_PLACE;
                end else begin
                    j_d = j_q + 4'd1;
                end
            end
            S_PLACE: begin
                ram_d[i_q] = ram_q[hi_q];
                ram_d[hi_q] = ram_q[i_q];
                push_a = 1'b1;
                push_b = 1'b1;
                // Edge indices push an explicitly empty (lo>hi) range instead of wrapping.
                if (i_q == 4'hF) begin
                    a_lo = 4'hF;
                    a_hi = 4'h0;
                end else begin
                    a_lo = i_q + 4'd1;
                    a_hi = hi_q;
                end
                if (i_q == 4'h0) begin
                    b_lo = 4'h1;
                    b_hi = 4'h0;
                end else begin
                    b_lo = lo_q;
                    b_hi = i_q - 4'd1;
                end
                state_d = S_POP;
            end
            S_DONE: begin
                done_port = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        for (int unsigned c = 0; c < 2; c++) begin
            if (ch_wr[c]) begin
                ram_d[offset_of(ch_addr[c], MEM_var_29131_28866)] =
                    (ram_q[offset_of(ch_addr[c], MEM_var_29131_28866)] & ~ch_mask[c]) |
                    (ch_wdata[c] & ch_mask[c]);
            end
        end
    end

    // State, datapath, RAM and slave response registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            i_q     <= '0;
            j_q     <= '0;
            pivot_q <= '0;
            ram_q   <= '{default: '0};
            rdata_q <= '0;
            rdy_q   <= '0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            i_q     <= i_d;
            j_q     <= j_d;
            pivot_q <= pivot_d;
            ram_q   <= ram_d;
            rdata_q <= rdata_d;
            rdy_q   <= rdy_d;
        end
    end

endmodule

// File: tb/tb_quicksort_main.sv
// Scoreboard bench for quicksort_main: stimulus queues expected slave
// responses, a monitor pops and compares them whenever DataRdy is raised.
module tb_quicksort_main;

    localparam int unsigned BASE = 32;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_port;
    logic [1:0]  S_oe_ram, S_we_ram;
    logic [13:0] S_addr_ram;
    logic [15:0] S_Wdata_ram;
    logic [7:0]  S_data_ram_size;
    logic [15:0] M_Rdata_ram;
    logic [1:0]  M_DataRdy;
    logic        done_port;
    logic [15:0] Sout_Rdata_ram;
    logic [1:0]  Sout_DataRdy;
    logic [1:0]  Mout_oe_ram, Mout_we_ram;
    logic [13:0] Mout_addr_ram;
    logic [15:0] Mout_Wdata_ram;
    logic [7:0]  Mout_data_ram_size;

    quicksort_main #(
        .MEM_var_28860_28869 (32),
        .MEM_var_29131_28866 (32)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .start_port         (start_port),
        .S_oe_ram           (S_oe_ram),
        .S_we_ram           (S_we_ram),
        .S_addr_ram         (S_addr_ram),
        .S_Wdata_ram        (S_Wdata_ram),
        .S_data_ram_size    (S_data_ram_size),
        .M_Rdata_ram        (M_Rdata_ram),
        .M_DataRdy          (M_DataRdy),
        .done_port          (done_port),
        .Sout_Rdata_ram     (Sout_Rdata_ram),
        .Sout_DataRdy       (Sout_DataRdy),
        .Mout_oe_ram        (Mout_oe_ram),
        .Mout_we_ram        (Mout_we_ram),
        .Mout_addr_ram      (Mout_addr_ram),
        .Mout_Wdata_ram     (Mout_Wdata_ram),
        .Mout_data_ram_size (Mout_data_ram_size)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          done_cnt = 0;

    typedef struct {
        logic [7:0]  data;
        int unsigned cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    logic [7:0] sorted [16] = '{8'h80, 8'hCE, 8'hFD, 8'hFF, 8'h00, 8'h02, 8'h05, 8'h07,
                                8'h07, 8'h0C, 8'h12, 8'h21, 8'h2D, 8'h40, 8'h63, 8'h7F};

    // Cycle stamp used to check response latency.
    always @(posedge clock) cyc <= cyc + 1;

    // Count completion pulses.
    always @(negedge clock) begin
        if (done_port === 1'b1) done_cnt++;
    end

    // Response monitor: pops the per-channel expectation whenever DataRdy is seen.
    always @(negedge clock) begin
        exp_t e;
        if (reset === 1'b0) begin
            if (q0.size() != 0 && q0[0].cyc < cyc) begin
                n_vec++; n_err++;
                e = q0.pop_front();
                $display("FAIL ch0_missing_rdy due_cyc=%0d now=%0d", e.cyc, cyc);
            end
            if (Sout_DataRdy[0] === 1'b1) begin
                n_vec++;
                if (q0.size() == 0) begin
                    n_err++;
                    $display("FAIL ch0_spurious_rdy got data=%h at cyc=%0d, required no rdy", Sout_Rdata_ram[7:0], cyc);
                end else begin
                    e = q0.pop_front();
                    if (Sout_Rdata_ram[7:0] !== e.data || cyc != e.cyc) begin
                        n_err++;
                        $display("FAIL ch0_resp got data=%h cyc=%0d, required data=%h cyc=%0d",
                                 Sout_Rdata_ram[7:0], cyc, e.data, e.cyc);
                    end
                end
            end
            if (q1.size() != 0 && q1[0].cyc < cyc) begin
                n_vec++; n_err++;
                e = q1.pop_front();
                $display("FAIL ch1_missing_rdy due_cyc=%0d now=%0d", e.cyc, cyc);
            end
            if (Sout_DataRdy[1] === 1'b1) begin
                n_vec++;
                if (q1.size() == 0) begin
                    n_err++;
                    $display("FAIL ch1_spurious_rdy got data=%h at cyc=%0d, required no rdy", Sout_Rdata_ram[15:8], cyc);
                end else begin
                    e = q1.pop_front();
                    if (Sout_Rdata_ram[15:8] !== e.data || cyc != e.cyc) begin
                        n_err++;
                        $display("FAIL ch1_resp got data=%h cyc=%0d, required data=%h cyc=%0d",
                                 Sout_Rdata_ram[15:8], cyc, e.data, e.cyc);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    // One-cycle slave request; expected responses are queued for the monitor.
    task automatic drive(input logic [1:0] oe, input logic [1:0] we,
                         input logic [6:0] a0, input logic [6:0] a1,
                         input logic [7:0] d0, input logic [7:0] d1,
                         input logic [3:0] s0, input logic [3:0] s1,
                         input logic [1:0] exp_rdy, input logic [7:0] e0, input logic [7:0] e1);
        exp_t e;
        @(posedge clock); #1;
        S_oe_ram        = oe;
        S_we_ram        = we;
        S_addr_ram      = {a1, a0};
        S_Wdata_ram     = {d1, d0};
        S_data_ram_size = {s1, s0};
        e.cyc = cyc + 1;
        if (exp_rdy[0]) begin e.data = e0; q0.push_back(e); end
        if (exp_rdy[1]) begin e.data = e1; q1.push_back(e); end
        @(posedge clock); #1;
        S_oe_ram        = '0;
        S_we_ram        = '0;
        S_addr_ram      = '0;
        S_Wdata_ram     = '0;
        S_data_ram_size = '0;
    endtask

    task automatic rd(input int ch, input logic [6:0] addr, input logic [7:0] exp_v);
        if (ch == 0) drive(2'b01, 2'b00, addr, 7'd0, 8'h00, 8'h00, 4'd8, 4'd8, 2'b01, exp_v, 8'h00);
        else         drive(2'b10, 2'b00, 7'd0, addr, 8'h00, 8'h00, 4'd8, 4'd8, 2'b10, 8'h00, exp_v);
    endtask

    task automatic wr(input int ch, input logic [6:0] addr, input logic [7:0] data,
                      input logic [3:0] size, input logic ack);
        if (ch == 0) drive(2'b00, 2'b01, addr, 7'd0, data, 8'h00, size, 4'd0, {1'b0, ack}, 8'h00, 8'h00);
        else         drive(2'b00, 2'b10, 7'd0, addr, 8'h00, data, 4'd0, size, {ack, 1'b0}, 8'h00, 8'h00);
    endtask

    task automatic pulse_start();
        @(posedge clock); #1; start_port = 1'b1;
        @(posedge clock); #1; start_port = 1'b0;
    endtask

    task automatic wait_done(input int prev, input int limit);
        int k;
        k = 0;
        while (done_cnt == prev && k < limit) begin
            @(negedge clock);
            k++;
        end
        n_vec++;
        if (done_cnt == prev) begin
            n_err++;
            $display("FAIL done_timeout got no done_port within %0d cycles", limit);
        end
    endtask

    task automatic read_all(input logic zero);
        for (int k = 0; k < 16; k++) begin
            rd(k % 2, 7'(BASE + k), zero ? 8'h00 : sorted[k]);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_done"}, {63'd0, done_port}, 64'd0);
        chk({tag, "_rdata"}, {48'd0, Sout_Rdata_ram}, 64'd0);
        chk({tag, "_rdy"}, {62'd0, Sout_DataRdy}, 64'd0);
        chk({tag, "_mout"}, {22'd0, Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int prev;
        reset = 1'b1; start_port = 1'b0;
        S_oe_ram = '0; S_we_ram = '0; S_addr_ram = '0; S_Wdata_ram = '0; S_data_ram_size = '0;
        M_Rdata_ram = '0; M_DataRdy = '0;
        repeat (3) @(negedge clock);
        chk_outputs_zero("reset");
        @(posedge clock); #1; reset = 1'b0;
        read_all(1'b1);

        // First sort: single done pulse, sorted contents.
        prev = done_cnt;
        pulse_start();
        wait_done(prev, 600);
        @(negedge clock);
        chk("done_one_cycle", {63'd0, done_port}, 64'd0);
        chk("done_count_sort1", 64'(done_cnt), 64'(prev + 1));
        read_all(1'b0);

        // Channel 1 read of base+3, exact latency and lane.
        rd(1, 7'(BASE + 3), 8'hFF);
        chk("ch1_rdy_lane", {62'd0, Sout_DataRdy}, 64'd2);
        chk("ch1_rdata", {48'd0, Sout_Rdata_ram}, 64'hFF00);
        @(posedge clock); #1;
        chk("ch1_rdy_drop", {62'd0, Sout_DataRdy}, 64'd0);

        // Window boundaries.
        drive(2'b01, 2'b00, 7'd0, 7'd0, 8'h00, 8'h00, 4'd8, 4'd8, 2'b00, 8'h00, 8'h00);
        chk("oor_addr0_rdy", {62'd0, Sout_DataRdy}, 64'd0);
        chk("oor_addr0_data", {48'd0, Sout_Rdata_ram}, 64'd0);
        drive(2'b10, 2'b00, 7'd0, 7'(BASE + 16), 8'h00, 8'h00, 4'd8, 4'd8, 2'b00, 8'h00, 8'h00);
        chk("oor_end_rdy", {62'd0, Sout_DataRdy}, 64'd0);
        chk("oor_end_data", {48'd0, Sout_Rdata_ram}, 64'd0);
        drive(2'b01, 2'b00, 7'(BASE - 1), 7'd0, 8'h00, 8'h00, 4'd8, 4'd8, 2'b00, 8'h00, 8'h00);
        chk("oor_below_rdy", {62'd0, Sout_DataRdy}, 64'd0);
        rd(0, 7'(BASE + 15), 8'h7F);

        // Second sort from the sorted state gives the same result.
        prev = done_cnt;
        pulse_start();
        wait_done(prev, 600);
        read_all(1'b0);

        // Extra start while sorting is ignored; a write while sorting is dropped.
        prev = done_cnt;
        pulse_start();
        repeat (20) @(posedge clock);
        pulse_start();
        wr(0, 7'(BASE + 1), 8'h55, 4'd8, 1'b0);
        chk("busy_write_no_rdy", {62'd0, Sout_DataRdy}, 64'd0);
        wait_done(prev, 600);
        repeat (650) @(negedge clock);
        chk("done_count_busy_start", 64'(done_cnt), 64'(prev + 1));
        read_all(1'b0);

        // Masked writes in IDLE.
        wr(0, 7'(BASE), 8'h80, 4'd8, 1'b1);
        rd(0, 7'(BASE), 8'h80);
        wr(0, 7'(BASE), 8'h5A, 4'd8, 1'b1);
        rd(1, 7'(BASE), 8'h5A);
        wr(0, 7'(BASE), 8'h80, 4'd4, 1'b1);
        rd(0, 7'(BASE), 8'h50);

        // Same-address write on both channels: channel 1 wins.
        drive(2'b00, 2'b11, 7'(BASE + 2), 7'(BASE + 2), 8'h11, 8'h22, 4'd8, 4'd8, 2'b11, 8'h00, 8'h00);
        rd(0, 7'(BASE + 2), 8'h22);

        // oe and we together: read of old value served, write ignored.
        drive(2'b01, 2'b01, 7'(BASE + 5), 7'd0, 8'hAA, 8'h00, 4'd8, 4'd8, 2'b01, 8'h02, 8'h00);
        rd(1, 7'(BASE + 5), 8'h02);

        // Reset 50 cycles into a sort aborts it and clears the RAM.
        prev = done_cnt;
        pulse_start();
        repeat (50) @(posedge clock);
        #1; reset = 1'b1;
        @(negedge clock);
        chk_outputs_zero("midsort_reset");
        @(posedge clock); #1; reset = 1'b0;
        repeat (700) @(negedge clock);
        chk("done_count_after_abort", 64'(done_cnt), 64'(prev));
        chk_outputs_zero("after_abort");
        read_all(1'b1);

        repeat (3) @(negedge clock);
        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
